// File: rtl/rr_mux4_arbiter.sv
// Purpose : round-robin arbiter steering one of four requesters onto a shared valid/ready output.
// Latency : grant registered 1 cycle after req; data path is combinational (0 cycles d -> y).
// Backpress: y_ready low holds the grant and the transfer count; a grant is released only on
//            request drop or after MAX_HOLD accepted transfers while another requester waits.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   req[3:0]         per-requester request; d0..d3 carry the matching data words
//   y, y_valid       selected data and its valid (busy & req[sel])
//   y_ready          downstream accept
//   gnt, sel, busy   registered one-hot grant, its index, and grant-held flag
module rr_mux4_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic          y_ready,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_d;
  logic [1:0] sel_d;
  logic [1:0] ptr_q, ptr_d;     // index served last; searched last on the next pick
  logic [7:0] cnt_q, cnt_d;     // accepted transfers in the current grant, saturating

  logic       transfer;
  logic [3:0] others;
  logic       release_now;
  logic [1:0] pick_idle;
  logic [1:0] pick_next;

  // Search last+1 .. last+4 (mod 4); last itself is checked only as the final candidate.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && mask[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign busy     = (state_q == GRANT);
  assign y_valid  = busy & req[sel];
  assign transfer = y_valid & y_ready;
  assign others   = req & ~(4'b0001 << sel);

  // A saturated counter only forces a release once someone else is actually waiting.
  assign release_now = !req[sel] || (transfer && (cnt_q == CNT_MAX) && (others != 4'b0000));

  assign pick_idle = rr_pick(ptr_q, req);
  // On release ptr becomes sel, so the current owner is searched last.
  assign pick_next = rr_pick(sel, others);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_idle;
          sel_d   = pick_idle;
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel;
          cnt_d = 8'd0;
          if (others != 4'b0000) begin
            gnt_d = 4'b0001 << pick_next;
            sel_d = pick_next;
          end else begin
            // sel is left as-is so the output mux does not move while idle.
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (transfer && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    y = '0;
    if (busy) begin
      case (sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
module tb_rr_mux4_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] d0, d1, d2, d3;
  logic       y_ready;

  logic [7:0] y;
  logic       y_valid;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  logic [7:0] y1;
  logic       y_valid1;
  logic [3:0] gnt1;
  logic [1:0] sel1;
  logic       busy1;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  rr_mux4_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .y_ready(y_ready), .y(y), .y_valid(y_valid),
    .gnt(gnt), .sel(sel), .busy(busy)
  );

  rr_mux4_arbiter #(.DW(8), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .y_ready(y_ready), .y(y1), .y_valid(y_valid1),
    .gnt(gnt1), .sel(sel1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; y_ready = 1'b1;
    tick(); tick();
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || y_valid !== 1'b0 || y !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: gnt=%b sel=%0d busy=%b y_valid=%b y=%h required 0000 0 0 0 00",
               gnt, sel, busy, y_valid, y);
    end
    rst = 1'b0;
    req = 4'b0000;
    tick();
  endtask

  // req=0101, MAX_HOLD=4: 4 transfers from 0, 4 from 2, then back to 0 with no bubble.
  task automatic test_rr_hold();
    exp_t e;
    logic [3:0] eg;
    do_reset();
    req = 4'b0101; y_ready = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_hold_latency: busy=%b required 0 before edge", busy);
    end
    for (int i = 0; i < 4; i++) sb.push_back('{sel: 2'd0, dat: 8'hA0});
    for (int i = 0; i < 4; i++) sb.push_back('{sel: 2'd2, dat: 8'hA2});
    sb.push_back('{sel: 2'd0, dat: 8'hA0});
    tick();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (!(y_valid === 1'b1 && y_ready === 1'b1)) begin
        errors++; $display("FAIL rr_hold_valid cyc %0d: y_valid=%b required 1", i, y_valid);
      end else if (sb.size() == 0) begin
        errors++; $display("FAIL rr_hold_sb cyc %0d: unexpected transfer, scoreboard empty", i);
      end else begin
        e  = sb.pop_front();
        eg = 4'b0001 << e.sel;
        if (sel !== e.sel || y !== e.dat || gnt !== eg) begin
          errors++;
          $display("FAIL rr_hold_xfer cyc %0d: gnt=%b sel=%0d y=%h required %b %0d %h",
                   i, gnt, sel, y, eg, e.sel, e.dat);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rr_hold_left: %0d entries left, required 0", sb.size());
    end
    sb.delete();
  endtask

  // MAX_HOLD=1 instance with all four requesting: strict rotation every transfer.
  task automatic test_alternation();
    exp_t e;
    do_reset();
    req = 4'b1111; y_ready = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back('{sel: 2'(i % 4), dat: 8'hA0 + 8'(i % 4)});
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (y_valid1 !== 1'b1) begin
        errors++; $display("FAIL alt_valid cyc %0d: y_valid=%b required 1", i, y_valid1);
      end else if (sb.size() == 0) begin
        errors++; $display("FAIL alt_sb cyc %0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (sel1 !== e.sel || y1 !== e.dat) begin
          errors++;
          $display("FAIL alt_xfer cyc %0d: sel=%0d y=%h required %0d %h", i, sel1, y1, e.sel, e.dat);
        end
      end
      tick();
    end
    sb.delete();
  endtask

  // Lone requester keeps the grant past the limit; a new contender takes over after one transfer.
  task automatic test_single_hold();
    exp_t e;
    do_reset();
    req = 4'b0010; y_ready = 1'b1;
    for (int i = 0; i < 11; i++) sb.push_back('{sel: 2'd1, dat: 8'hA1});
    tick();
    for (int i = 0; i < 11; i++) begin
      if (i == 10) req = 4'b1010;
      checks++;
      if (y_valid !== 1'b1 || gnt !== 4'b0010) begin
        errors++; $display("FAIL single_hold cyc %0d: gnt=%b y_valid=%b required 0010 1", i, gnt, y_valid);
      end else if (sb.size() == 0) begin
        errors++; $display("FAIL single_sb cyc %0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (sel !== e.sel || y !== e.dat) begin
          errors++; $display("FAIL single_xfer cyc %0d: sel=%0d y=%h required %0d %h", i, sel, y, e.sel, e.dat);
        end
      end
      tick();
    end
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || y !== 8'hA3) begin
      errors++; $display("FAIL single_handover: gnt=%b sel=%0d y=%h required 1000 3 a3", gnt, sel, y);
    end
    sb.delete();
  endtask

  // Backpressure holds the grant; dropping the request with y_ready high gives no transfer.
  task automatic test_stall_drop();
    do_reset();
    req = 4'b0010; y_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gnt !== 4'b0010 || y_valid !== 1'b1 || y !== 8'hA1) begin
        errors++; $display("FAIL stall_hold cyc %0d: gnt=%b y_valid=%b y=%h required 0010 1 a1", i, gnt, y_valid, y);
      end
      tick();
    end
    req = 4'b0000; y_ready = 1'b1;
    #1;
    checks++;
    if (y_valid !== 1'b0) begin
      errors++; $display("FAIL drop_valid: y_valid=%b required 0", y_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || y !== 8'h00 || y_valid !== 1'b0) begin
      errors++; $display("FAIL drop_idle: busy=%b gnt=%b y=%h y_valid=%b required 0 0000 00 0", busy, gnt, y, y_valid);
    end
  endtask

  // Mid-grant reset clears grant and restores the round-robin pointer to 3.
  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100; y_ready = 1'b1;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || y_valid !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: gnt=%b y_valid=%b required 0100 1", gnt, y_valid);
    end
    rst = 1'b1; req = 4'b1100;
    tick();
    rst = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || y !== 8'h00) begin
      errors++; $display("FAIL mid_reset_clear: gnt=%b busy=%b sel=%0d y=%h required 0000 0 0 00", gnt, busy, sel, y);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      errors++; $display("FAIL mid_reset_ptr: gnt=%b sel=%0d required 0100 2", gnt, sel);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; y_ready = 1'b0;
    d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
    test_reset();
    test_rr_hold();
    test_alternation();
    test_single_hold();
    test_stall_drop();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexed output channel between four requesters.
- Registers a one-hot grant, drives the 2-bit mux select (sel[1]=s1, sel[0]=s0) and steers the granted requester's data word to the output under a valid/ready handshake.
- Enforces a per-grant transfer limit so that no requester can starve the others.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
- DW, 8, width of each data input and of y.
- MAX_HOLD, 4, maximum accepted transfers per grant while another requester is waiting (1..255).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] high means producer i has data on d_i.
- d0  input  DW  data from requester 0.
- d1  input  DW  data from requester 1.
- d2  input  DW  data from requester 2.
- d3  input  DW  data from requester 3.
- y_ready  input  1  downstream accepts y this cycle.
- y  output  DW  selected data; d[sel] when busy, else 0.
- y_valid  output  1  busy & req[sel].
- gnt  output  4  one-hot registered grant; 0 when idle.
- sel  output  2  registered mux select {s1,s0}; equals the index of the set gnt bit.
- busy  output  1  high while a grant is held (state GRANT).

Behaviour:
- Reset values: state=IDLE, gnt=0, sel=0, busy=0, y_valid=0, y=0, ptr=3 (last-served index), cnt=0. Requester 0 has first priority after reset.
- rst is sampled only on the clock edge. Asserting it mid-transfer aborts the grant at that edge with no transfer counted, even if y_ready=1 in that cycle.
- Round-robin pick: search indices ptr+1, ptr+2, ptr+3, ptr+4 (mod 4) over a candidate mask; the first set bit wins.
- IDLE:
  - If req!=0, pick a winner with mask=req. Next cycle: state=GRANT, gnt=onehot(winner), sel=winner, cnt=0.
  - Grant latency is 1 cycle from req rising to busy/gnt.
- GRANT:
  - transfer = y_valid & y_ready.
  - cnt increments on each transfer and saturates at MAX_HOLD-1.
  - others = req with bit sel cleared.
- Release conditions, evaluated every GRANT cycle:
  - (a) req[sel]=0.
  - (b) transfer & cnt==MAX_HOLD-1 & others!=0.
- On release:
  - ptr <= sel.
  - Pick the next winner from mask=others. With ptr updated, the current index is always searched last.
  - If others!=0: stay in GRANT with the new gnt/sel and cnt=0, with no idle bubble.
  - Otherwise: go to IDLE with gnt=0, sel unchanged, busy=0.
- Hold limit with no contenders: at cnt==MAX_HOLD-1 with others=0, the current requester keeps the grant. cnt stays saturated; the limit re-arms the moment another request appears and the next transfer releases.
- y is purely combinational from the registered sel: y=d[sel] when busy, else 0. No data is registered, so data latency is 0 cycles from d to y.
- sel and gnt never change in a cycle where they are not re-arbitrated. Both outputs are glitch-free between edges.
- Requests arriving while busy only take effect at the next release; they are never lost while held high.
- Simultaneous events:
  - A request rising in the same cycle as a release is included in that release's pick.
  - A request dropping in the same cycle as y_ready produces no transfer, because y_valid is already low.
- MAX_HOLD=1: release after every transfer whenever others!=0, giving strict alternation.

Test Plan:
- Reset then req=4'b0101, y_ready=1, MAX_HOLD=4, requests held:
  - gnt=0001, sel=0 one cycle after req.
  - After 4 transfers, gnt=0100 and sel=2 with no bubble.
  - After 4 more transfers, gnt returns to 0001.
- req=4'b1111 held, y_ready=1, d_i=8'hA0+i, MAX_HOLD=1: y sequence A0,A1,A2,A3,A0 on consecutive cycles; sel cycles 0,1,2,3,0.
- req=4'b0010 alone, y_ready=1 for 10 cycles: gnt stays 0010 for all 10 transfers (hold limit ignored, no contenders).
- Then raise req[3] while cnt is saturated: gnt=1000 after the next single transfer.
- Grant to 1 with y_ready=0 for 5 cycles, then drop req[1] with req=0:
  - Transfer count is 0 throughout.
  - busy=0 and gnt=0 next cycle; y=0 and y_valid=0.
- Mid-grant, with gnt=0100 and y_valid=1, assert rst for 1 cycle:
  - Next cycle gnt=0, busy=0, sel=0, y=0.
  - With req=4'b1100 afterwards, the first grant after reset is index 2 (ptr back to 3, search starts at 0).
